// File: rtl/conv_pkg.sv
// Shared definitions for the convolution datapath.
// Holds the default operand/partial-sum widths and the window-control
// FSM state encoding used by mac_psum_unit.
package conv_pkg;

    localparam int IF_W     = 8;   // signed IF operand width
    localparam int FILTER_W = 8;   // signed filter operand width
    localparam int PSUM_W   = 20;  // partial-sum / output width

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,  // waiting for the first pair of a convolution
        ST_RUN   = 2'd1,  // accepting pairs
        ST_DRAIN = 2'd2,  // Done seen, flushing pipeline and partial window
        ST_FIN   = 2'd3   // everything drained, held until start/reset
    } conv_state_e;

endpackage

// File: rtl/psum_out_reg.sv
// Single-entry valid/ready output register.
// Ports:
//   clk, rst        - clock, asynchronous active-low reset
//   clr             - synchronous clear of the held entry
//   push, push_data - load a new result (caller guarantees the slot is free
//                     or being drained this cycle)
//   out_ready       - downstream accepts the held entry
//   out_valid, out_data - held result, stable until transferred
module psum_out_reg
    import conv_pkg::*;
#(
    parameter int WIDTH = PSUM_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (clr) begin
            valid_d = 1'b0;
            data_d  = '0;
        end else if (push) begin
            // A push in the same cycle as a transfer refills the slot with
            // no bubble.
            valid_d = 1'b1;
            data_d  = push_data;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge value of every other flop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;

endmodule

// File: rtl/mac_psum_unit.sv
// Multiply-accumulate partial-sum unit for one convolution stream.
// Stage P registers the signed product with first/last-of-window tags,
// stage A accumulates and hands each finished window to psum_out_reg.
// Ports:
//   clk, rst                 - clock, asynchronous active-low reset
//   start                    - synchronous clear before a new convolution
//   can_mult, mult_ready     - operand pair handshake
//   if_data, filter_data     - signed operands
//   filter_size              - taps per window (0 treated as 1)
//   Done                     - level: no further pairs will follow
//   out_valid/out_ready/out_data - result handshake to the scratchpad
//   partial_err              - sticky: Done arrived mid-window
//   all_done                 - sticky: everything drained after Done
module mac_psum_unit
    import conv_pkg::*;
#(
    parameter int IF_CELL_SIZE     = IF_W,
    parameter int FILTER_CELL_SIZE = FILTER_W,
    parameter int PSUM_SIZE        = PSUM_W
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        can_mult,
    input  logic [IF_CELL_SIZE-1:0]     if_data,
    input  logic [FILTER_CELL_SIZE-1:0] filter_data,
    input  logic [2:0]                  filter_size,
    input  logic                        Done,
    output logic                        mult_ready,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [PSUM_SIZE-1:0]        out_data,
    output logic                        partial_err,
    output logic                        all_done
);

    localparam int PROD_SIZE = IF_CELL_SIZE + FILTER_CELL_SIZE;

    logic signed [PROD_SIZE-1:0] p_prod_q, p_prod_d;
    logic                        p_valid_q, p_valid_d;
    logic                        p_first_q, p_first_d;
    logic                        p_last_q, p_last_d;
    logic [PSUM_SIZE-1:0]        acc_q, acc_d;
    logic [2:0]                  tap_cnt_q, tap_cnt_d;
    logic [2:0]                  fs_q, fs_d;
    conv_state_e                 state_q, state_d;
    logic                        partial_err_q, partial_err_d;
    logic                        all_done_q, all_done_d;

    logic                        stall, accept, is_first, is_last;
    logic                        a_push, flush, push;
    logic [2:0]                  win_len;
    logic [PSUM_SIZE-1:0]        prod_ext, sum, push_data;
    logic signed [PROD_SIZE-1:0] prod_now;

    // A finished window waiting behind an unconsumed result freezes P.
    assign stall      = p_valid_q & p_last_q & out_valid & ~out_ready;
    assign mult_ready = ~stall & ((state_q == ST_IDLE) | (state_q == ST_RUN));
    assign accept     = can_mult & mult_ready & ~start;

    // NOTE: every variable gets a default at the top of always_comb so no
    // path leaves it unassigned, which would infer a latch.
    always_comb begin
        p_prod_d      = p_prod_q;
        p_valid_d     = p_valid_q;
        p_first_d     = p_first_q;
        p_last_d      = p_last_q;
        acc_d         = acc_q;
        tap_cnt_d     = tap_cnt_q;
        fs_d          = fs_q;
        state_d       = state_q;
        partial_err_d = partial_err_q;

        prod_now = $signed(if_data) * $signed(filter_data);
        prod_ext = PSUM_SIZE'(p_prod_q);  // sign-extends the signed product
        sum      = p_first_q ? prod_ext : acc_q + prod_ext;

        // Window length is latched on the first pair; later changes ignored.
        is_first = (tap_cnt_q == 3'd0);
        win_len  = is_first ? ((filter_size == 3'd0) ? 3'd1 : filter_size) : fs_q;
        is_last  = (tap_cnt_q == win_len - 3'd1);

        a_push    = p_valid_q & p_last_q & ~stall;
        // Partial window is emitted only once P is empty so acc is complete.
        flush     = (state_q == ST_DRAIN) & ~p_valid_q & (tap_cnt_q != 3'd0)
                  & (~out_valid | out_ready);
        push      = a_push | flush;
        push_data = flush ? acc_q : sum;

        if (!stall) begin
            p_valid_d = accept;
            p_prod_d  = prod_now;
            p_first_d = is_first;
            p_last_d  = is_last;
            if (p_valid_q) acc_d = p_last_q ? '0 : sum;
        end

        if (accept) begin
            if (is_first) fs_d = win_len;
            tap_cnt_d = is_last ? 3'd0 : tap_cnt_q + 3'd1;
        end

        if (flush) begin
            acc_d     = '0;
            tap_cnt_d = 3'd0;
        end

        case (state_q)
            ST_IDLE:  if (accept) state_d = ST_RUN;
            ST_RUN:   if (Done) state_d = ST_DRAIN;
            ST_DRAIN: begin
                if (tap_cnt_q != 3'd0) partial_err_d = 1'b1;
                if (!p_valid_q && !out_valid && tap_cnt_q == 3'd0) state_d = ST_FIN;
            end
            default:  state_d = state_q;
        endcase

        if (start) begin
            p_valid_d     = 1'b0;
            acc_d         = '0;
            tap_cnt_d     = 3'd0;
            state_d       = ST_IDLE;
            partial_err_d = 1'b0;
        end

        all_done_d = (state_d == ST_FIN);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            p_prod_q      <= '0;
            p_valid_q     <= 1'b0;
            p_first_q     <= 1'b0;
            p_last_q      <= 1'b0;
            acc_q         <= '0;
            tap_cnt_q     <= 3'd0;
            fs_q          <= 3'd1;
            state_q       <= ST_IDLE;
            partial_err_q <= 1'b0;
            all_done_q    <= 1'b0;
        end else begin
            p_prod_q      <= p_prod_d;
            p_valid_q     <= p_valid_d;
            p_first_q     <= p_first_d;
            p_last_q      <= p_last_d;
            acc_q         <= acc_d;
            tap_cnt_q     <= tap_cnt_d;
            fs_q          <= fs_d;
            state_q       <= state_d;
            partial_err_q <= partial_err_d;
            all_done_q    <= all_done_d;
        end
    end

    assign partial_err = partial_err_q;
    assign all_done    = all_done_q;

    psum_out_reg #(
        .WIDTH(PSUM_SIZE)
    ) u_out_reg (
        .clk       (clk),
        .rst       (rst),
        .clr       (start),
        .push      (push & ~start),
        .push_data (push_data),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data)
    );

endmodule

// File: tb/tb_mac_psum_unit.sv
// Bench for mac_psum_unit: a 20-bit and a 16-bit instance share stimulus;
// a window-level reference model predicts every result.
module tb_mac_psum_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        can_mult = 1'b0;
    logic        done = 1'b0;
    logic        out_ready = 1'b0;
    logic [7:0]  if_data = '0;
    logic [7:0]  filter_data = '0;
    logic [2:0]  filter_size = '0;

    logic        mult_ready, out_valid, partial_err, all_done;
    logic [19:0] out_data;
    logic        mult_ready16, out_valid16, partial_err16, all_done16;
    logic [15:0] out_data16;

    int     n_cmp = 0;
    int     n_bad = 0;
    longint exp_q[$];
    int     win_cnt = 0;
    int     win_fs = 1;
    longint win_sum = 0;
    bit     exp_partial = 0;
    bit     rand_ready = 0;
    bit     prev_hold = 0;
    logic [19:0] prev_data = '0;
    longint mon_e;

    always #5 clk = ~clk;

    mac_psum_unit u_dut (
        .clk(clk), .rst(rst), .start(start), .can_mult(can_mult),
        .if_data(if_data), .filter_data(filter_data), .filter_size(filter_size),
        .Done(done), .mult_ready(mult_ready), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data),
        .partial_err(partial_err), .all_done(all_done)
    );

    mac_psum_unit #(.PSUM_SIZE(16)) u_dut16 (
        .clk(clk), .rst(rst), .start(start), .can_mult(can_mult),
        .if_data(if_data), .filter_data(filter_data), .filter_size(filter_size),
        .Done(done), .mult_ready(mult_ready16), .out_valid(out_valid16),
        .out_ready(out_ready), .out_data(out_data16),
        .partial_err(partial_err16), .all_done(all_done16)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: windows of max(filter_size,1) products, length
    // captured at each window's first pair.
    task automatic model_clear();
        exp_q.delete();
        win_cnt = 0;
        win_sum = 0;
        exp_partial = 0;
    endtask

    task automatic model_accept(input int a, input int b);
        if (win_cnt == 0) win_fs = (filter_size == 3'd0) ? 1 : int'(filter_size);
        win_sum += longint'(a * b);
        win_cnt++;
        if (win_cnt == win_fs) begin
            exp_q.push_back(win_sum);
            win_sum = 0;
            win_cnt = 0;
        end
    endtask

    task automatic model_done();
        if (win_cnt != 0) begin
            exp_q.push_back(win_sum);
            exp_partial = 1;
            win_cnt = 0;
            win_sum = 0;
        end
    endtask

    // Offer one pair; returns just after the accepting edge.
    task automatic send_pair(input int a, input int b, input int gap);
        int waited = 0;
        bit ok = 1;
        can_mult    = 1'b1;
        if_data     = 8'(a);
        filter_data = 8'(b);
        forever begin
            @(negedge clk);
            if (mult_ready) break;
            waited++;
            if (waited > 300) begin
                check("accept_timeout", mult_ready, 1);
                ok = 0;
                break;
            end
        end
        if (ok) model_accept(a, b);
        tick();
        can_mult = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        can_mult = 1'b0;
        done = 1'b0;
        start = 1'b0;
        model_clear();
        repeat (3) tick();
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_mult_ready", mult_ready, 1);
        check("rst_partial_err", partial_err, 0);
        check("rst_all_done", all_done, 0);
        check("rst_mult_ready16", mult_ready16, 1);
        rst = 1'b1;
        tick();
    endtask

    task automatic do_start();
        start = 1'b1;
        model_clear();
        tick();
        start = 1'b0;
        check("start_all_done", all_done, 0);
        check("start_partial_err", partial_err, 0);
        check("start_out_valid", out_valid, 0);
    endtask

    task automatic finish_round();
        int waited = 0;
        done = 1'b1;
        model_done();
        while (!all_done && waited < 500) begin
            tick();
            waited++;
        end
        check("all_done", all_done, 1);
        check("all_done16", all_done16, 1);
        check("partial_err", partial_err, exp_partial);
        check("partial_err16", partial_err16, exp_partial);
        check("fin_mult_ready", mult_ready, 0);
        check("fin_drained", exp_q.size(), 0);
        done = 1'b0;
        do_start();
    endtask

    // Output monitor: checks every transfer against the model and that a
    // refused result stays put.
    always @(negedge clk) begin
        if (rst && !start) begin
            if (prev_hold) begin
                check("hold_valid", out_valid, 1);
                check("hold_data", out_data, prev_data);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out", out_valid, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("out_data20", out_data, mon_e & 64'hF_FFFF);
                    check("out_data16", out_data16, mon_e & 64'hFFFF);
                    check("out_valid16", out_valid16, 1);
                end
            end
            prev_hold = out_valid && !out_ready;
            prev_data = out_data;
        end else begin
            prev_hold = 0;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (rand_ready) out_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        do_reset();
        out_ready = 1'b1;

        // Three-tap window, latency and single-cycle pulse.
        filter_size = 3'd3;
        send_pair(2, 3, 0);
        send_pair(-1, 4, 0);
        send_pair(5, 5, 0);
        check("lat_before", out_valid, 0);
        tick();
        check("lat_valid", out_valid, 1);
        check("lat_data", out_data, 27);
        tick();
        check("lat_pulse", out_valid, 0);

        // filter_size 0 acts as one tap; extreme operands.
        filter_size = 3'd0;
        send_pair(-128, -128, 0);
        send_pair(127, 127, 0);
        repeat (4) tick();
        check("fs0_drained", exp_q.size(), 0);

        // Backpressure: results held, intake stalls, nothing lost.
        filter_size = 3'd2;
        out_ready = 1'b0;
        fork
            begin
                for (int i = 1; i <= 6; i++) send_pair(i, 2, 0);
            end
            begin
                repeat (12) tick();
                check("bp_mult_ready", mult_ready, 0);
                check("bp_valid", out_valid, 1);
                check("bp_data", out_data, 6);
                out_ready = 1'b1;
            end
        join
        repeat (5) tick();
        check("bp_drained", exp_q.size(), 0);

        // Done mid-window flushes the partial sum.
        do_start();
        filter_size = 3'd4;
        send_pair(1, 1, 0);
        send_pair(1, 1, 0);
        finish_round();

        // Seven max products: exact at 20 bits, wraps at 16 bits.
        filter_size = 3'd7;
        for (int i = 0; i < 7; i++) send_pair(127, 127, 0);
        tick();
        check("wide_valid", out_valid, 1);
        check("wide_exact", out_data, 112903);
        check("wide_wrap16", out_data16, 16'hB907);

        // Reset with a result pending discards it.
        filter_size = 3'd2;
        out_ready = 1'b0;
        send_pair(3, 3, 0);
        send_pair(3, 3, 0);
        tick();
        check("pend_valid", out_valid, 1);
        do_reset();
        out_ready = 1'b1;
        repeat (5) tick();
        check("no_stale", out_valid, 0);

        // Reset mid-window, then a fresh window.
        send_pair(7, 7, 0);
        do_reset();
        send_pair(1, 1, 0);
        send_pair(2, 2, 0);
        tick();
        check("fresh_valid", out_valid, 1);
        check("fresh_data", out_data, 5);
        finish_round();

        // Randomized rounds: random operands, gaps, backpressure and
        // filter_size changing on every pair.
        rand_ready = 1;
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < 40; k++) begin
                filter_size = 3'($urandom_range(0, 7));
                send_pair(int'($urandom_range(0, 255)) - 128,
                          int'($urandom_range(0, 255)) - 128,
                          int'($urandom_range(0, 2)));
            end
            finish_round();
        end
        rand_ready = 0;
        out_ready = 1'b1;
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
